// File: rtl/mptw_req_arbiter.sv
// mptw_req_arbiter: round-robin front end that shares one MPT walker between NUM_REQ requesters.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset (also resets the walker)
//   flush_i                  abort a pending or in-flight walk; no response is issued for it
//   mptw_enable_i            MPT checking enabled; low grants are answered at once (bypass)
//   req_valid_i/req_ready_o  per-requester handshake; ready is one-hot or zero, only in IDLE
//   req_spa_i/req_access_i   packed per-requester SPA and access type, requester k at slice k
//   walk_*                   walker request (valid/ready/spa/access) and completion (done/fault/format)
//   rsp_valid_o              one-cycle pulse to the granted requester
//   rsp_fault_o              registered verdict, holds between pulses
//   rsp_format_err_o         registered format error cause, holds between pulses
//   busy_o                   FSM is not IDLE
//
// Optional feature (macro MPTW_ARB_TIMEOUT_EN): a watchdog in WAIT/DRAIN. After TIMEOUT_CYCLES-1
// cycles without walk_done_i, WAIT answers with a fault plus an rsp_timeout_o pulse, and DRAIN
// returns silently to IDLE.
module mptw_req_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned SPA_W          = 56,
    parameter int unsigned ACC_W          = 2,
    parameter int unsigned FMT_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       mptw_enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*SPA_W-1:0]   req_spa_i,
    input  logic [NUM_REQ*ACC_W-1:0]   req_access_i,
    output logic                       walk_valid_o,
    input  logic                       walk_ready_i,
    output logic [SPA_W-1:0]           walk_spa_o,
    output logic [ACC_W-1:0]           walk_access_o,
    input  logic                       walk_done_i,
    input  logic                       walk_fault_i,
    input  logic [FMT_W-1:0]           walk_format_err_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic                       rsp_fault_o,
    output logic [FMT_W-1:0]           rsp_format_err_o,
`ifdef MPTW_ARB_TIMEOUT_EN
    output logic                       rsp_timeout_o,
`endif
    output logic                       busy_o
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, BYPASS, ISSUE, WAIT, DRAIN, RESP} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, win;
    logic [SPA_W-1:0]   spa_q, spa_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               fault_q, fault_d;
    logic [FMT_W-1:0]   fmt_q, fmt_d;
    logic               found, grant;
    int                 idx;

`ifdef MPTW_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d, to_hit;
    assign to_hit        = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign rsp_timeout_o = timeout_q;
`endif

    // First valid requester at or after rr_ptr_q, wrapping around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign grant = (state_q == IDLE) && found && !flush_i;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        spa_d    = spa_q;
        acc_d    = acc_q;
        fault_d  = fault_q;
        fmt_d    = fmt_q;
`ifdef MPTW_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (grant) begin
                gnt_d    = win;
                rr_ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                spa_d    = req_spa_i[win*SPA_W +: SPA_W];
                acc_d    = req_access_i[win*ACC_W +: ACC_W];
                state_d  = mptw_enable_i ? ISSUE : BYPASS;
                // The bypass verdict is "allowed"; load it now so it shows in the BYPASS cycle.
                if (!mptw_enable_i) begin
                    fault_d = 1'b0;
                    fmt_d   = '0;
                end
            end
            BYPASS: state_d = IDLE;
            // A flush coinciding with the handshake still leaves a walk in flight, so drain it.
            ISSUE: state_d = walk_ready_i ? (flush_i ? DRAIN : WAIT) : (flush_i ? IDLE : ISSUE);
            WAIT: begin
                if (flush_i) begin
                    state_d = walk_done_i ? IDLE : DRAIN;
                end else if (walk_done_i) begin
                    state_d = RESP;
                    fault_d = walk_fault_i;
                    fmt_d   = walk_format_err_i;
                end
`ifdef MPTW_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    state_d   = RESP;
                    fault_d   = 1'b1;
                    fmt_d     = '0;
                    timeout_d = 1'b1;
                end
`endif
            end
`ifdef MPTW_ARB_TIMEOUT_EN
            DRAIN: state_d = (walk_done_i || to_hit) ? IDLE : DRAIN;
`else
            DRAIN: state_d = walk_done_i ? IDLE : DRAIN;
`endif
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MPTW_ARB_TIMEOUT_EN
    // Counts only while staying in WAIT or DRAIN; any entry (including WAIT->DRAIN) restarts it.
    assign cnt_d = ((state_q == WAIT || state_q == DRAIN) && state_d == state_q) ? cnt_q + 1'b1 : '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            spa_q    <= '0;
            acc_q    <= '0;
            fault_q  <= 1'b0;
            fmt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            spa_q    <= spa_d;
            acc_q    <= acc_d;
            fault_q  <= fault_d;
            fmt_q    <= fmt_d;
        end
    end

`ifdef MPTW_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign req_ready_o      = grant ? NUM_REQ'(1) << win : '0;
    assign walk_valid_o     = state_q == ISSUE;
    assign walk_spa_o       = spa_q;
    assign walk_access_o    = acc_q;
    assign rsp_valid_o      = (state_q == BYPASS || state_q == RESP) ? NUM_REQ'(1) << gnt_q : '0;
    assign rsp_fault_o      = fault_q;
    assign rsp_format_err_o = fmt_q;
    assign busy_o           = state_q != IDLE;
endmodule

// File: tb/tb_mptw_req_arbiter.sv
// tb_mptw_req_arbiter: randomized self-checking bench for mptw_req_arbiter against a round-robin reference model.
module tb_mptw_req_arbiter;
    localparam int N = 2, SW = 56, AW = 2, FW = 2;

    logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, mptw_enable_i = 1'b0;
    logic [N-1:0] req_valid_i = '0;
    logic walk_ready_i = 1'b0, walk_done_i = 1'b0, walk_fault_i = 1'b0;
    logic [FW-1:0] walk_format_err_i = '0;
    logic [SW-1:0] spa [N];
    logic [AW-1:0] acc [N];
    wire [N*SW-1:0] req_spa_i;
    wire [N*AW-1:0] req_access_i;
    wire [N-1:0] req_ready_o, rsp_valid_o;
    wire walk_valid_o, rsp_fault_o, busy_o;
    wire [SW-1:0] walk_spa_o;
    wire [AW-1:0] walk_access_o;
    wire [FW-1:0] rsp_format_err_o;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_spa_i[g*SW +: SW]    = spa[g];
        assign req_access_i[g*AW +: AW] = acc[g];
    end

    mptw_req_arbiter #(.NUM_REQ(N), .SPA_W(SW), .ACC_W(AW), .FMT_W(FW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .mptw_enable_i(mptw_enable_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_spa_i(req_spa_i),
        .req_access_i(req_access_i), .walk_valid_o(walk_valid_o), .walk_ready_i(walk_ready_i),
        .walk_spa_o(walk_spa_o), .walk_access_o(walk_access_o), .walk_done_i(walk_done_i),
        .walk_fault_i(walk_fault_i), .walk_format_err_i(walk_format_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_fault_o(rsp_fault_o), .rsp_format_err_o(rsp_format_err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;
    int rr = 0;
    int last_gnt = -1;
    logic last_fault = 1'b0;
    logic [FW-1:0] last_fmt = '0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_addrs();
        for (int k = 0; k < N; k++) begin
            spa[k] = SW'({$urandom, $urandom});
            acc[k] = AW'($urandom);
        end
    endtask

    // Round-robin rule: first valid index at or after the pointer, modulo N.
    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One full transaction from IDLE back to IDLE; requesters keep v asserted throughout.
    task automatic run_txn(input logic [N-1:0] v, input bit en, input int hold, input int lat,
                           input logic f, input logic [FW-1:0] fm);
        int w;
        logic [SW-1:0] es;
        logic [AW-1:0] ea;
        logic [N-1:0] eg;
        req_valid_i = v;
        mptw_enable_i = en;
        #1;
        w = model_winner(v, rr);
        eg = N'(1) << w;
        n_chk++; if (req_ready_o !== eg) begin n_fail++; $display("FAIL grant: req_ready_o=%b expected %b", req_ready_o, eg); end
        es = spa[w];
        ea = acc[w];
        rr = (w + 1) % N;
        last_gnt = w;
        tick();
        rand_addrs();
        mptw_enable_i = 1'($urandom);
        #1;
        n_chk++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL busy_ready: req_ready_o=%b expected 0", req_ready_o); end
        if (!en) begin
            n_chk++; if (rsp_valid_o !== eg || rsp_fault_o !== 1'b0 || rsp_format_err_o !== '0 || walk_valid_o !== 1'b0)
                begin n_fail++; $display("FAIL bypass_rsp: rsp_valid=%b fault=%b fmt=%0d walk_valid=%b expected %b/0/0/0", rsp_valid_o, rsp_fault_o, rsp_format_err_o, walk_valid_o, eg); end
            last_fault = 1'b0;
            last_fmt = '0;
            tick();
        end else begin
            n_chk++; if (walk_valid_o !== 1'b1 || walk_spa_o !== es || walk_access_o !== ea || rsp_valid_o !== '0)
                begin n_fail++; $display("FAIL issue: walk_valid=%b spa=%h acc=%0d rsp=%b expected 1/%h/%0d/0", walk_valid_o, walk_spa_o, walk_access_o, rsp_valid_o, es, ea); end
            for (int i = 0; i < hold; i++) begin
                walk_ready_i = 1'b0;
                tick();
                n_chk++; if (walk_valid_o !== 1'b1 || walk_spa_o !== es || walk_access_o !== ea)
                    begin n_fail++; $display("FAIL issue_hold: walk_valid=%b spa=%h expected 1/%h", walk_valid_o, walk_spa_o, es); end
            end
            walk_ready_i = 1'b1;
            tick();
            walk_ready_i = 1'b0;
            for (int i = 0; i < lat; i++) begin
                #1;
                n_chk++; if (rsp_valid_o !== '0 || busy_o !== 1'b1 || walk_valid_o !== 1'b0)
                    begin n_fail++; $display("FAIL wait: rsp=%b busy=%b walk_valid=%b expected 0/1/0", rsp_valid_o, busy_o, walk_valid_o); end
                tick();
            end
            walk_done_i = 1'b1;
            walk_fault_i = f;
            walk_format_err_i = fm;
            tick();
            walk_done_i = 1'b0;
            walk_fault_i = 1'($urandom);
            walk_format_err_i = FW'($urandom);
            #1;
            n_chk++; if (rsp_valid_o !== eg || rsp_fault_o !== f || rsp_format_err_o !== fm)
                begin n_fail++; $display("FAIL walk_rsp: rsp=%b fault=%b fmt=%0d expected %b/%b/%0d", rsp_valid_o, rsp_fault_o, rsp_format_err_o, eg, f, fm); end
            last_fault = f;
            last_fmt = fm;
            tick();
        end
        req_valid_i = '0;
        #1;
        n_chk++; if (busy_o !== 1'b0 || rsp_valid_o !== '0 || rsp_fault_o !== last_fault || rsp_format_err_o !== last_fmt)
            begin n_fail++; $display("FAIL back_idle: busy=%b rsp=%b fault=%b fmt=%0d expected 0/0/%b/%0d", busy_o, rsp_valid_o, rsp_fault_o, rsp_format_err_o, last_fault, last_fmt); end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        n_chk++; if ({req_ready_o, walk_valid_o, walk_spa_o, walk_access_o, rsp_valid_o, rsp_fault_o, rsp_format_err_o, busy_o} !== '0)
            begin n_fail++; $display("FAIL reset_outputs: busy=%b walk_valid=%b rsp=%b fault=%b nonzero", busy_o, walk_valid_o, rsp_valid_o, rsp_fault_o); end
        rst_ni = 1'b1;
        tick();
        n_chk++; if (busy_o !== 1'b0 || walk_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release: busy=%b walk_valid=%b expected 0/0", busy_o, walk_valid_o); end
        rr = 0;
    endtask

    task automatic test_single();
        spa[0] = 56'h8000_1000;
        acc[0] = '0;
        run_txn(2'b01, 1'b1, 0, 4, 1'b0, '0);
    endtask

    task automatic test_round_robin();
        int prev;
        prev = last_gnt;
        for (int i = 0; i < 6; i++) begin
            rand_addrs();
            run_txn(2'b11, 1'b1, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), FW'($urandom));
            n_chk++; if (last_gnt == prev) begin n_fail++; $display("FAIL rr_repeat: granted %0d twice in a row", last_gnt); end
            prev = last_gnt;
        end
    endtask

    task automatic test_bypass();
        rand_addrs();
        run_txn(2'b10, 1'b0, 0, 0, 1'b0, '0);
        rand_addrs();
        run_txn(2'b11, 1'b0, 0, 0, 1'b0, '0);
    endtask

    task automatic test_flush_issue();
        int w;
        logic [SW-1:0] es;
        rand_addrs();
        req_valid_i = 2'b01;
        mptw_enable_i = 1'b1;
        #1;
        w = model_winner(2'b01, rr);
        rr = (w + 1) % N;
        es = spa[w];
        tick();
        req_valid_i = '0;
        rand_addrs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (walk_valid_o !== 1'b1 || walk_spa_o !== es || rsp_valid_o !== '0)
                begin n_fail++; $display("FAIL bp_stable: walk_valid=%b spa=%h rsp=%b expected 1/%h/0", walk_valid_o, walk_spa_o, rsp_valid_o, es); end
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        n_chk++; if (walk_valid_o !== 1'b0 || busy_o !== 1'b0 || rsp_valid_o !== '0)
            begin n_fail++; $display("FAIL flush_issue: walk_valid=%b busy=%b rsp=%b expected 0/0/0", walk_valid_o, busy_o, rsp_valid_o); end
        flush_i = 1'b1;
        req_valid_i = 2'b11;
        #1;
        n_chk++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL flush_idle: req_ready_o=%b expected 0", req_ready_o); end
        tick();
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: busy=%b expected 0", busy_o); end
        flush_i = 1'b0;
        req_valid_i = '0;
    endtask

    task automatic start_walk();
        int w;
        rand_addrs();
        req_valid_i = N'($urandom_range(1, (1 << N) - 1));
        mptw_enable_i = 1'b1;
        #1;
        w = model_winner(req_valid_i, rr);
        rr = (w + 1) % N;
        tick();
        req_valid_i = '0;
        walk_ready_i = 1'b1;
        tick();
        walk_ready_i = 1'b0;
    endtask

    task automatic test_flush_wait();
        start_walk();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (busy_o !== 1'b1 || rsp_valid_o !== '0) begin n_fail++; $display("FAIL drain: busy=%b rsp=%b expected 1/0", busy_o, rsp_valid_o); end
            tick();
        end
        walk_done_i = 1'b1;
        walk_fault_i = 1'b1;
        #1;
        n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drain_done: busy=%b expected 1", busy_o); end
        tick();
        walk_done_i = 1'b0;
        walk_fault_i = 1'b0;
        #1;
        n_chk++; if (busy_o !== 1'b0 || rsp_valid_o !== '0 || rsp_fault_o !== last_fault)
            begin n_fail++; $display("FAIL drain_end: busy=%b rsp=%b fault=%b expected 0/0/%b", busy_o, rsp_valid_o, rsp_fault_o, last_fault); end
        rand_addrs();
        run_txn(2'b10, 1'b1, 1, 2, 1'b1, 2'd2);
        start_walk();
        flush_i = 1'b1;
        walk_done_i = 1'b1;
        walk_fault_i = 1'b0;
        walk_format_err_i = 2'd3;
        tick();
        flush_i = 1'b0;
        walk_done_i = 1'b0;
        #1;
        n_chk++; if (busy_o !== 1'b0 || rsp_valid_o !== '0 || rsp_fault_o !== last_fault || rsp_format_err_o !== last_fmt)
            begin n_fail++; $display("FAIL flush_done: busy=%b rsp=%b fault=%b fmt=%0d expected 0/0/%b/%0d", busy_o, rsp_valid_o, rsp_fault_o, rsp_format_err_o, last_fault, last_fmt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid_i = '0;
                #1;
                n_chk++; if (req_ready_o !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_empty: ready=%b busy=%b expected 0/0", req_ready_o, busy_o); end
                tick();
            end
            rand_addrs();
            run_txn(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                    $urandom_range(0, 5), 1'($urandom), FW'($urandom));
        end
    endtask

    task automatic test_async_reset();
        start_walk();
        #2;
        rst_ni = 1'b0;
        #1;
        n_chk++; if (busy_o !== 1'b0 || walk_valid_o !== 1'b0 || rsp_fault_o !== 1'b0 || rsp_format_err_o !== '0)
            begin n_fail++; $display("FAIL async_reset: busy=%b walk_valid=%b fault=%b fmt=%0d expected all 0", busy_o, walk_valid_o, rsp_fault_o, rsp_format_err_o); end
        tick();
        rst_ni = 1'b1;
        rr = 0;
        last_fault = 1'b0;
        last_fmt = '0;
        tick();
        rand_addrs();
        run_txn(2'b11, 1'b1, 0, 1, 1'b1, 2'd1);
    endtask

    initial begin
        rand_addrs();
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_flush_issue();
        test_flush_wait();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mptw_req_arbiter.md
Name: mptw_req_arbiter

Overview:
- Front-end scheduler for the MPT walker (mptw_top) that shares it between NUM_REQ requesters (e.g. I-side and D-side PLB miss ports).
- Grants one requester at a time using round-robin, issues a single walk and waits for completion.
- Returns the walker verdict to the granted requester.
- Handles flush and the M-mode bypass (mptw_enable_i low) without occupying the walker.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SPA_W, $bits(spa_t_u), width of one supervisor physical address.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with MPTW_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  abort pending/in-flight walk
- mptw_enable_i  in  1  MPT checking enabled (low = bypass)
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accepted (one-hot or zero)
- req_spa_i  in  NUM_REQ*SPA_W  packed SPAs, requester k at [k*SPA_W +: SPA_W]
- req_access_i  in  NUM_REQ*$bits(mpt_access_e)  packed access types
- walk_valid_o  out  1  walk request to walker (transaction_valid_i)
- walk_ready_i  in  1  walker ready (mptw_ready_o)
- walk_spa_o  out  SPA_W  SPA to walker
- walk_access_o  out  $bits(mpt_access_e)  access type to walker
- walk_done_i  in  1  walker completion pulse
- walk_fault_i  in  1  walker access_page_fault_o, sampled with walk_done_i
- walk_format_err_i  in  $bits(page_format_fault_e)  walker format_error_o, sampled with walk_done_i
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the granted requester
- rsp_fault_o  out  1  access denied
- rsp_format_err_o  out  $bits(page_format_fault_e)  format error cause
- busy_o  out  1  FSM not IDLE

Interface decision: one clock clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0. rsp_format_err_o is the enum's zero (no-fault) encoding. rr_ptr = 0. FSM = IDLE.
- Arbitration:
  - Round-robin starting at rr_ptr; the winner is the first valid index at or after rr_ptr (mod NUM_REQ).
  - On grant, rr_ptr <= winner+1 (wraps at NUM_REQ).
  - The winner's SPA and access type are latched into internal registers.
- IDLE, any req_valid_i, flush_i=0:
  - req_ready_o[winner]=1 combinationally, latch, then:
  - mptw_enable_i=1 -> ISSUE.
  - mptw_enable_i=0 -> BYPASS.
  - flush_i=1 in IDLE: no grant.
- BYPASS (1 cycle): rsp_valid_o[gnt]=1, rsp_fault_o=0, format=0 -> IDLE. Walker untouched; request-to-response latency is 1 cycle.
- ISSUE:
  - walk_valid_o=1 with latched spa/access, held stable until walk_ready_i.
  - valid&ready -> WAIT.
  - flush_i -> IDLE, walk_valid_o dropped, no response.
- WAIT:
  - walk_done_i -> RESP, latching fault and format error.
  - flush_i without done -> DRAIN.
  - flush_i with done in the same cycle -> IDLE, result discarded.
- DRAIN: wait for walk_done_i, discard the result -> IDLE. No responses are issued.
- RESP (1 cycle):
  - rsp_valid_o[gnt]=1 with the latched verdict -> IDLE.
  - flush_i in RESP does not suppress the pulse.
- Response signals:
  - rsp_fault_o and rsp_format_err_o are registered and hold their last value between pulses.
  - Requesters have no response backpressure.
- req_ready_o is 0 in every state except IDLE, so at most one transaction is in flight.
- Minimum latency: grant -> walk_valid_o next cycle. walk_done_i -> rsp_valid_o next cycle.
- mptw_enable_i is sampled only at grant; a change mid-walk does not affect the current transaction.
- Async reset mid-walk returns to IDLE immediately. The walker is reset by the same rst_ni.

Optional Feature:
- Macro: MPTW_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT or DRAIN and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES-1 without walk_done_i:
    - From WAIT: go to RESP with rsp_fault_o=1, format=0, and a one-cycle rsp_timeout_o pulse (extra 1-bit output).
    - From DRAIN: go to IDLE silently.
  - A late walk_done_i arriving in IDLE is ignored.
- When undefined: no counter and no rsp_timeout_o port; WAIT and DRAIN wait indefinitely.

Test Plan:
- Single request:
  - Stimulus: enable=1, req0 SPA=0x8000_1000, access=read; walker ready immediately, done 5 cycles later with fault=0.
  - Response: walk_spa_o=0x8000_1000; rsp_valid_o=2'b01 exactly one cycle after done; fault=0.
- Round-robin:
  - Stimulus: req0 and req1 held valid continuously; each walk completes.
  - Response: grants alternate 0,1,0,1; no requester is granted twice in a row.
- Bypass:
  - Stimulus: enable=0, req1 valid.
  - Response: req_ready_o=2'b10, rsp_valid_o=2'b10 the next cycle; walk_valid_o never asserted.
- Backpressure and flush in ISSUE:
  - Stimulus: walk_ready_i=0 for 3 cycles with walk_spa_o checked stable, then flush_i.
  - Response: walk_valid_o drops next cycle; state IDLE; no rsp_valid_o.
- Flush in WAIT:
  - Stimulus: flush_i, then walk_done_i with fault=1 4 cycles later.
  - Response: no rsp_valid_o; busy_o falls the cycle after done; a new request is granted after that.
- Timeout (MPTW_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: walk accepted, walk_done_i never asserted.
  - Response: rsp_valid_o pulses with fault=1 and rsp_timeout_o=1 at cycle 16 of WAIT.
